// File: rtl/messbauer_pkg.sv
// Shared definitions for the Mossbauer CAMAC accumulator: RAM geometry,
// spectrum RAM arbiter states and CAMAC function codes.
package messbauer_pkg;

  localparam int unsigned AW_DEF = 12;
  localparam int unsigned DW_DEF = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_RD  = 3'd1,
    ACC_WR  = 3'd2,
    CLR     = 3'd3,
    CAM_RD  = 3'd4,
    CAM_RDD = 3'd5,
    CAM_WR  = 3'd6
  } ram_arb_state_t;

  localparam logic [4:0] F_READ  = 5'd0;
  localparam logic [4:0] F_CLEAR = 5'd9;
  localparam logic [4:0] F_WRITE = 5'd16;

endpackage

// File: rtl/messbauer_sat_adder.sv
// DW-bit unsigned add that clamps to all-ones when the carry out is set.
module messbauer_sat_adder #(
  parameter int unsigned DW = 24
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum_c,
  output logic          ovf_c
);

  logic [DW:0] full_sum;

  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b};
    ovf_c    = full_sum[DW];
    sum_c    = full_sum[DW] ? {DW{1'b1}} : full_sum[DW-1:0];
  end

endmodule

// File: rtl/messbauer_spectrum_ram_arbiter.sv
// Sequences every cycle of the single-port spectrum RAM between channel
// accumulation (read-modify-write), the clear sweep and CAMAC access.
module messbauer_spectrum_ram_arbiter
  import messbauer_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_req,
  input  logic [AW-1:0] acc_addr,
  input  logic [DW-1:0] acc_data,
  output logic          acc_ack,
  input  logic          cam_req,
  input  logic          cam_we,
  input  logic [AW-1:0] cam_addr,
  input  logic [DW-1:0] cam_wdata,
  output logic [DW-1:0] cam_rdata,
  output logic          cam_ack,
  input  logic          clr_req,
  output logic          clr_busy,
  input  logic          flag_clr,
  output logic          sat,
  output logic          ovf,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  ram_arb_state_t state, state_nxt, arb_nxt;

  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] wrk_addr;
  logic [DW-1:0] wrk_data;
  logic [AW-1:0] clr_ptr;
  logic          cam_armed;
  logic [DW-1:0] cam_rdata_q;

  logic          consume_c;
  logic          capture_c;
  logic          drop_c;
  logic          acc_pend_c;
  logic          clr_last_c;
  logic          clr_go_c;
  logic          cam_go_c;
  logic [DW-1:0] sum_c;
  logic          carry_c;

  messbauer_sat_adder #(
    .DW (DW)
  ) u_sat_adder (
    .a     (ram_rdata),
    .b     (wrk_data),
    .sum_c (sum_c),
    .ovf_c (carry_c)
  );

  // Request qualification; a new accumulation counts as pending in the cycle it is captured
  always_comb begin
    consume_c  = (state == ACC_RD);
    capture_c  = acc_req & (~pend_valid | consume_c);
    drop_c     = acc_req & ~capture_c;
    acc_pend_c = pend_valid | capture_c;
    clr_last_c = (state == CLR) && (clr_ptr == LAST_ADDR);
    clr_go_c   = clr_req | (clr_busy & ~clr_last_c);
    cam_go_c   = cam_req & cam_armed & ~cam_ack;
    acc_ack    = capture_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Fixed priority: accumulation, then clear sweep, then CAMAC
  always_comb begin
    arb_nxt = IDLE;
    if (acc_pend_c)    arb_nxt = ACC_RD;
    else if (clr_go_c) arb_nxt = CLR;
    else if (cam_go_c) arb_nxt = cam_we ? CAM_WR : CAM_RD;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC_RD:  state_nxt = ACC_WR;
      CAM_RD:  state_nxt = CAM_RDD;
      default: state_nxt = arb_nxt;
    endcase
  end

  // RAM strobes are decoded from state so reset drops ram_we at once
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    cam_ack   = 1'b0;
    unique case (state)
      ACC_RD: ram_addr = pend_addr;
      ACC_WR: begin
        ram_addr  = wrk_addr;
        ram_we    = 1'b1;
        ram_wdata = sum_c;
      end
      CLR: begin
        ram_addr = clr_ptr;
        ram_we   = 1'b1;
      end
      CAM_RD: ram_addr = cam_addr;
      CAM_RDD: begin
        ram_addr = cam_addr;
        cam_ack  = 1'b1;
      end
      CAM_WR: begin
        ram_addr  = cam_addr;
        ram_we    = 1'b1;
        ram_wdata = cam_wdata;
        cam_ack   = 1'b1;
      end
      default: ;
    endcase
    cam_rdata = (state == CAM_RDD) ? ram_rdata : cam_rdata_q;
  end

  // Pending entry plus a working copy, so a new capture cannot corrupt the write in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      wrk_addr   <= '0;
      wrk_data   <= '0;
    end else begin
      if (capture_c) begin
        pend_addr <= acc_addr;
        pend_data <= acc_data;
      end
      if (capture_c)      pend_valid <= 1'b1;
      else if (consume_c) pend_valid <= 1'b0;
      if (consume_c) begin
        wrk_addr <= pend_addr;
        wrk_data <= pend_data;
      end
    end
  end

  // Clear sweep progress; a fresh clr_req always restarts from cell 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_ptr  <= '0;
      clr_busy <= 1'b0;
    end else begin
      if (clr_req)            clr_ptr <= '0;
      else if (state == CLR)  clr_ptr <= clr_ptr + AW'(1);
      if (clr_req)            clr_busy <= 1'b1;
      else if (clr_last_c)    clr_busy <= 1'b0;
    end
  end

  // CAMAC edge re-arm and read-data hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cam_armed   <= 1'b1;
      cam_rdata_q <= '0;
    end else begin
      if (cam_ack)       cam_armed <= 1'b0;
      else if (!cam_req) cam_armed <= 1'b1;
      if (state == CAM_RDD) cam_rdata_q <= ram_rdata;
    end
  end

  // Sticky flags; a setting event beats flag_clr and sweep start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if ((state == ACC_WR) && carry_c) sat <= 1'b1;
      else if (flag_clr || clr_req)     sat <= 1'b0;
      if (drop_c)                       ovf <= 1'b1;
      else if (flag_clr || clr_req)     ovf <= 1'b0;
    end
  end

endmodule
